// File: rtl/simple_uart_pkg.sv
// simple_uart_pkg: shared constants and receiver state encoding for simple_uart
package simple_uart_pkg;
    localparam int          FRAME_BITS     = 10;
    localparam int          DUMMY_BITS_DEF = 15;
    localparam logic [31:0] DIV_RESET_DEF  = 32'd1;
    typedef enum logic [3:0] {
        RX_IDLE, RX_START,
        RX_DATA0, RX_DATA1, RX_DATA2, RX_DATA3,
        RX_DATA4, RX_DATA5, RX_DATA6, RX_DATA7,
        RX_STOP
    } rx_state_e;
endpackage

// File: rtl/simple_uart_if.sv
// simple_uart_if: per-register strobes and data between the SoC bus decode and the UART
interface simple_uart_if;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;
    modport master (
        output reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
        input  reg_div_do, reg_dat_do, reg_dat_wait
    );
    modport slave (
        input  reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
        output reg_div_do, reg_dat_do, reg_dat_wait
    );
endinterface

// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 receive FSM sampling mid-bit, with a one-byte overwrite buffer
module simple_uart_rx
    import simple_uart_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    input  logic [31:0] div,
    input  logic        re,
    output logic [31:0] dat_do
);
    rx_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d, buf_q, buf_d;
    logic        valid_q, valid_d;

    // receiver state registers
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
        end

    // frame sequencing; a completing frame overrides a same-cycle read
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        shift_d = shift_q;
        buf_d   = buf_q;
        valid_d = re ? 1'b0 : valid_q;
        if (state_q == RX_IDLE) begin
            cnt_d = '0;
            if (!ser_rx) state_d = RX_START;
        end else if (state_q == RX_START) begin
            if (cnt_q > (div >> 1)) begin
                state_d = RX_DATA0;
                cnt_d   = '0;
            end
        end else if (state_q == RX_STOP) begin
            if (cnt_q > div) begin
                buf_d   = shift_q;
                valid_d = 1'b1;
                state_d = RX_IDLE;
            end
        end else if (cnt_q > div) begin
            shift_d = {ser_rx, shift_q[7:1]};
            state_d = rx_state_e'(state_q + 4'd1);
            cnt_d   = '0;
        end
    end

    assign dat_do = valid_q ? {24'h0, buf_q} : 32'hFFFF_FFFF;
endmodule

// File: rtl/simple_uart.sv
// simple_uart: memory-mapped 8N1 UART; receiver built only when SIMPLE_UART_RX_EN is defined
module simple_uart
    import simple_uart_pkg::*;
#(
    parameter logic [31:0] DIV_RESET  = DIV_RESET_DEF,
    parameter int          DUMMY_BITS = DUMMY_BITS_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    simple_uart_if.slave bus,
    output logic         ser_tx,
    input  logic         ser_rx
);
    logic [31:0] div_q, div_d;
    logic [31:0] divcnt_q, divcnt_d;
    logic [9:0]  pat_q, pat_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dummy_q, dummy_d;

    // divider and transmitter registers
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            div_q    <= DIV_RESET;
            divcnt_q <= '0;
            pat_q    <= '1;
            cnt_q    <= '0;
            dummy_q  <= 1'b1;
        end else begin
            div_q    <= div_d;
            divcnt_q <= divcnt_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            dummy_q  <= dummy_d;
        end

    // byte-lane divider writes and transmit priority: idle burst, new byte, bit shift
    always_comb begin
        div_d    = div_q;
        divcnt_d = divcnt_q + 32'd1;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        dummy_d  = dummy_q;
        for (int i = 0; i < 4; i++)
            if (bus.reg_div_we[i]) div_d[8*i +: 8] = bus.reg_div_di[8*i +: 8];
        if (dummy_q && cnt_q == 4'd0) begin
            pat_d    = '1;
            cnt_d    = 4'(DUMMY_BITS);
            divcnt_d = '0;
            dummy_d  = 1'b0;
        end else if (bus.reg_dat_we && cnt_q == 4'd0) begin
            pat_d    = {1'b1, bus.reg_dat_di[7:0], 1'b0};
            cnt_d    = 4'(FRAME_BITS);
            divcnt_d = '0;
        end else if (cnt_q != 4'd0 && divcnt_q > div_q) begin
            pat_d    = {1'b1, pat_q[9:1]};
            cnt_d    = cnt_q - 4'd1;
            divcnt_d = '0;
        end
        if (|bus.reg_div_we) dummy_d = 1'b1;
    end

    assign ser_tx           = pat_q[0];
    assign bus.reg_div_do   = div_q;
    assign bus.reg_dat_wait = bus.reg_dat_we && (cnt_q != 4'd0 || dummy_q);

    logic unused_di;
    assign unused_di = ^bus.reg_dat_di[31:8];

`ifdef SIMPLE_UART_RX_EN
    simple_uart_rx u_rx (
        .clk    (clk),
        .resetn (resetn),
        .ser_rx (ser_rx),
        .div    (div_q),
        .re     (bus.reg_dat_re),
        .dat_do (bus.reg_dat_do)
    );
`else
    logic unused_rx;
    assign unused_rx      = ^{ser_rx, bus.reg_dat_re};
    assign bus.reg_dat_do = 32'hFFFF_FFFF;
`endif
endmodule

// File: tb/tb_simple_uart.sv
// tb_simple_uart: directed checks of divider, transmitter, receiver and reset behaviour
module tb_simple_uart;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic ser_rx = 1'b1;
    logic ser_tx;
    int   errors = 0;
    int   checks = 0;
    int   a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`ifdef SIMPLE_UART_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif

    simple_uart_if bus ();

    simple_uart dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .ser_tx (ser_tx),
        .ser_rx (ser_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic count_wait(input int limit, output int n, output logic all_high);
        n = 0;
        all_high = 1'b1;
        bus.reg_dat_we = 1'b1;
        #1;
        while (bus.reg_dat_wait && n < limit) begin
            all_high &= ser_tx;
            @(negedge clk);
            #1;
            n++;
        end
        bus.reg_dat_we = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input int re_at);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 120; i++) begin
            ser_rx = f[i / 12];
            bus.reg_dat_re = (i == re_at);
            @(negedge clk);
            #1;
        end
        bus.reg_dat_re = 1'b0;
    endtask

    task automatic rx_read();
        bus.reg_dat_re = 1'b1;
        @(negedge clk);
        #1;
        bus.reg_dat_re = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int stall;
        logic high;
        bus.reg_div_we = '0;
        bus.reg_div_di = '0;
        bus.reg_dat_we = 1'b0;
        bus.reg_dat_re = 1'b0;
        bus.reg_dat_di = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_div", bus.reg_div_do, 32'd1);
        check("rst_dat_do", bus.reg_dat_do, 32'hFFFF_FFFF);
        check("rst_wait_idle", 32'(bus.reg_dat_wait), 32'd0);
        resetn = 1'b0;
        count_wait(200, n, high);
        check("dummy_rst_len", 32'(n), 32'd46);
        check("dummy_rst_high", 32'(high), 32'd1);

        bus.reg_div_we = 4'b0011;
        bus.reg_div_di = 32'h1234_000A;
        @(negedge clk);
        #1;
        bus.reg_div_we = '0;
        check("div_write", bus.reg_div_do, 32'h0000_000A);
        count_wait(400, n, high);
        check("dummy_div_len", 32'(n), 32'd181);
        check("dummy_div_high", 32'(high), 32'd1);

        bus.reg_dat_di = 32'h0000_00A5;
        bus.reg_dat_we = 1'b1;
        #1;
        check("tx_accept_wait", 32'(bus.reg_dat_wait), 32'd0);
        stall = 0;
        for (int i = 0; i <= 120; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) bus.reg_dat_di = 32'h0000_005A;
            if (i % 12 == 0 && i < 120) check($sformatf("tx_bit%0d_first", i / 12), 32'(ser_tx), 32'(a5_seq[i / 12]));
            if (i % 12 == 11) check($sformatf("tx_bit%0d_last", i / 12), 32'(ser_tx), 32'(a5_seq[i / 12]));
            stall += int'(bus.reg_dat_wait);
        end
        check("tx_stall", 32'(stall), 32'd120);
        @(negedge clk);
        #1;
        bus.reg_dat_we = 1'b0;
        check("tx_second_start", 32'(ser_tx), 32'd0);
        repeat (130) @(negedge clk);
        #1;

        rx_frame(8'h3C, -1);
        check("rx_3c", bus.reg_dat_do, RX ? 32'h0000_003C : 32'hFFFF_FFFF);
        rx_read();
        check("rx_read_clear", bus.reg_dat_do, 32'hFFFF_FFFF);
        rx_frame(8'h11, -1);
        rx_frame(8'h22, -1);
        check("rx_overwrite", bus.reg_dat_do, RX ? 32'h0000_0022 : 32'hFFFF_FFFF);
        rx_frame(8'h77, 114);
        check("rx_read_vs_done", bus.reg_dat_do, RX ? 32'h0000_0077 : 32'hFFFF_FFFF);
        rx_read();
        check("rx_read_clear2", bus.reg_dat_do, 32'hFFFF_FFFF);

        bus.reg_dat_di = 32'h0000_00F0;
        bus.reg_dat_we = 1'b1;
        #1;
        check("tx2_accept_wait", 32'(bus.reg_dat_wait), 32'd0);
        @(negedge clk);
        #1;
        bus.reg_dat_we = 1'b0;
        check("tx2_start", 32'(ser_tx), 32'd0);
        repeat (30) @(negedge clk);
        #1;
        check("tx2_mid_bit", 32'(ser_tx), 32'd0);
        resetn = 1'b1;
        #1;
        check("mid_rst_ser_tx", 32'(ser_tx), 32'd1);
        check("mid_rst_div", bus.reg_div_do, 32'd1);
        check("mid_rst_dat_do", bus.reg_dat_do, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        count_wait(200, n, high);
        check("dummy_rerst_len", 32'(n), 32'd46);
        check("dummy_rerst_high", 32'(high), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
